// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between requesters and the shared timer.
// Requesters drive req/dur; the arbiter returns grant/done/busy/count.
interface timer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] dur;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [CNT_W-1:0]         count;

    modport master (
        output req, dur,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, dur,
        output grant, done, busy, count
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one up-counter between NUM_REQ requesters.
// Winner's duration is latched at grant; done pulses once on completion.
module timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    timer_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   tgt, tgt_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   own, own_n;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   own_inc;
    logic [CNT_W-1:0]   dur_a [NUM_REQ];

    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W:0] s);
        logic [IDX_W:0] r;
        r = (s >= NR) ? s - NR : s;
        return r[IDX_W-1:0];
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_dur
        assign dur_a[i] = bus.dur[i*CNT_W +: CNT_W];
    end

    // Scan downward so the nearest requester at or after ptr is kept.
    always_comb begin
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[wrap({1'b0, ptr} + (IDX_W+1)'(k))])
                win = wrap({1'b0, ptr} + (IDX_W+1)'(k));
        end
    end

    assign own_inc = wrap({1'b0, own} + (IDX_W+1)'(1));

    always_comb begin
        state_n = state;
        grant_n = grant;
        cnt_n   = cnt;
        tgt_n   = tgt;
        ptr_n   = ptr;
        own_n   = own;
        unique case (state)
            IDLE: begin
                grant_n = '0;
                if (|bus.req) begin
                    state_n        = RUN;
                    own_n          = win;
                    grant_n[win]   = 1'b1;
                    tgt_n          = dur_a[win];
                    cnt_n          = '0;
                end
            end
            RUN: begin
                if (!bus.req[own]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = own_inc;
                end else if (cnt == tgt) begin
                    state_n = DONE;
                end else if (ena) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = own_inc;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            cnt   <= '0;
            tgt   <= '0;
            ptr   <= '0;
            own   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            cnt   <= cnt_n;
            tgt   <= tgt_n;
            ptr   <= ptr_n;
            own   <= own_n;
        end
    end

    // done is the owner's grant bit qualified by the single DONE cycle.
    assign bus.grant = grant;
    assign bus.done  = (state == DONE) ? grant : '0;
    assign bus.busy  = (state != IDLE);
    assign bus.count = cnt;
endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: reset, single grant, round-robin,
// enable gating, abort, zero duration and reset mid-interval.
module tb_timer_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   checks = 0;
    int   errors = 0;

    timer_arbiter_if #(.NUM_REQ(4), .CNT_W(8)) bus ();

    timer_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g,
                           input logic [3:0] d, input logic b,
                           input logic [7:0] c);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".done"},  32'(bus.done),  32'(d));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
    endtask

    logic [3:0] rr_seq [5];

    initial begin
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;

        rst_n   = 1'b0;
        ena     = 1'b1;
        bus.req = '0;
        bus.dur = '0;
        tick();
        chk_all("rst1", 4'b0, 4'b0, 1'b0, 8'd0);
        tick();
        chk_all("rst2", 4'b0, 4'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 4'b0, 4'b0, 1'b0, 8'd0);

        // Single requester 1, duration 5
        bus.dur = {8'd0, 8'd0, 8'd5, 8'd0};
        bus.req = 4'b0010;
        tick();
        chk_all("single.grant", 4'b0010, 4'b0, 1'b1, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("single.run", 4'b0010, 4'b0, 1'b1, 8'(k));
        end
        tick();
        chk_all("single.done", 4'b0010, 4'b0010, 1'b1, 8'd5);
        bus.req = '0;
        tick();
        chk_all("single.end", 4'b0, 4'b0, 1'b0, 8'd5);

        // Reset to bring ptr back to 0 before the fairness run
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.dur = {4{8'd2}};
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk_all("rr.grant", rr_seq[n], 4'b0, 1'b1, 8'd0);
            tick();
            chk_all("rr.c1", rr_seq[n], 4'b0, 1'b1, 8'd1);
            tick();
            chk_all("rr.c2", rr_seq[n], 4'b0, 1'b1, 8'd2);
            tick();
            chk_all("rr.done", rr_seq[n], rr_seq[n], 1'b1, 8'd2);
            if (n == 4) bus.req = '0;
            tick();
            chk_all("rr.idle", 4'b0, 4'b0, 1'b0, 8'd2);
        end

        // Enable gating: requester 0, duration 3, ena low for 4 cycles
        bus.dur = {8'd0, 8'd10, 8'd0, 8'd3};
        bus.req = 4'b0001;
        tick();
        chk_all("ena.grant", 4'b0001, 4'b0, 1'b1, 8'd0);
        tick();
        chk_all("ena.c1", 4'b0001, 4'b0, 1'b1, 8'd1);
        ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all("ena.frozen", 4'b0001, 4'b0, 1'b1, 8'd1);
        end
        ena = 1'b1;
        tick();
        chk_all("ena.c2", 4'b0001, 4'b0, 1'b1, 8'd2);
        tick();
        chk_all("ena.c3", 4'b0001, 4'b0, 1'b1, 8'd3);
        tick();
        chk_all("ena.done", 4'b0001, 4'b0001, 1'b1, 8'd3);
        bus.req = '0;
        tick();
        chk_all("ena.end", 4'b0, 4'b0, 1'b0, 8'd3);

        // Abort: requester 2 (dur 10) drops at count 4
        bus.req = 4'b0100;
        tick();
        chk_all("abort.grant", 4'b0100, 4'b0, 1'b1, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_all("abort.run", 4'b0100, 4'b0, 1'b1, 8'(k));
        end
        bus.req = '0;
        tick();
        chk_all("abort.end", 4'b0, 4'b0, 1'b0, 8'd4);

        // ptr must now be 3: requester 3 wins over 0 and 2, dur 0
        bus.dur = {8'd0, 8'd10, 8'd0, 8'd3};
        bus.req = 4'b1101;
        tick();
        chk_all("zero.grant", 4'b1000, 4'b0, 1'b1, 8'd0);
        tick();
        chk_all("zero.done", 4'b1000, 4'b1000, 1'b1, 8'd0);
        bus.req = '0;
        tick();
        chk_all("zero.end", 4'b0, 4'b0, 1'b0, 8'd0);

        // Reset mid-interval: requester 2, dur 20, reset at count 7
        bus.dur = {8'd0, 8'd20, 8'd0, 8'd3};
        bus.req = 4'b0100;
        tick();
        chk_all("mid.grant", 4'b0100, 4'b0, 1'b1, 8'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_all("mid.run", 4'b0100, 4'b0, 1'b1, 8'(k));
        end
        rst_n   = 1'b0;
        bus.req = 4'b0101;
        tick();
        chk_all("mid.rst", 4'b0, 4'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick();
        chk_all("mid.restart", 4'b0001, 4'b0, 1'b1, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
